uart_apb_fifo: RTL and testbench

UART_APB_FIFO -- requirements
Module: uart_apb_fifo

---
 rtl/uart_apb_pkg.sv | 50 +++++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_apb_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_apb_fifo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - register map, field positions and decode helper for uart_apb_fifo
package uart_apb_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_ISR    = 4'hC;

  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_OVERRUN    = 4;
  localparam int ST_TX_LVL_LSB = 8;
  localparam int ST_RX_LVL_LSB = 16;
  localparam int LVL_FIELD_W   = 8;

  localparam int CTRL_RX_IE    = 0;
  localparam int CTRL_TX_IE    = 1;
  localparam int CTRL_OVR_IE   = 2;
  localparam int CTRL_TX_FLUSH = 3;
  localparam int CTRL_RX_FLUSH = 4;

  localparam int ISR_OVERRUN   = 4;

  typedef enum logic [1:0] {
    SEL_DATA   = 2'd0,
    SEL_STATUS = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_ISR    = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic ovr_ie;
    logic tx_ie;
    logic rx_ie;
  } ctrl_t;

  // Word-aligned offset to register select; alignment is checked separately.
  function automatic reg_sel_e reg_sel(input logic [3:0] off);
    case (off & 4'hC)
      ADDR_DATA:   reg_sel = SEL_DATA;
      ADDR_STATUS: reg_sel = SEL_STATUS;
      ADDR_CTRL:   reg_sel = SEL_CTRL;
      ADDR_ISR:    reg_sel = SEL_ISR;
      default:     reg_sel = SEL_DATA;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush; push while full is allowed when a pop frees the slot
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_apb_fifo.sv
// rtl/uart_apb_fifo.sv - zero-wait APB register front end with TX/RX character FIFOs for a UART core
module uart_apb_fifo
  import uart_apb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       padd,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              access;
  reg_sel_e          sel;
  logic              err;
  logic              wr_ok;
  logic              rd_ok;
  logic              ctrl_wr;
  logic              isr_wr;
  ctrl_t             ctrl;
  logic              rx_overrun;
  logic              ovr_set;

  logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic [LW-1:0]     tx_level, rx_level;
  logic [31:0]       status;
  logic              unused_bits;

  // Gating with rst aborts an in-flight access and forces outputs low at once.
  assign access = psel & penable & ~rst;
  assign sel    = reg_sel(padd[3:0]);

  always_comb begin
    err = 1'b0;
    if (access) begin
      if (padd[1:0] != 2'b00) begin
        err = 1'b1;
      end else if (pwrite) begin
        case (sel)
          SEL_STATUS: err = 1'b1;
          SEL_DATA:   err = tx_full | ~pstrb[0];
          default:    err = 1'b0;
        endcase
      end else if (sel == SEL_DATA) begin
        err = rx_empty;
      end
    end
  end

  assign wr_ok    = access & pwrite & ~err;
  assign rd_ok    = access & ~pwrite & ~err;
  assign ctrl_wr  = wr_ok & (sel == SEL_CTRL);
  assign isr_wr   = wr_ok & (sel == SEL_ISR);

  assign tx_push  = wr_ok & (sel == SEL_DATA);
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_flush = ctrl_wr & pwdata[CTRL_TX_FLUSH];

  assign rx_pop   = rd_ok & (sel == SEL_DATA);
  assign rx_push  = rx_valid & (~rx_full | rx_pop);
  assign rx_flush = ctrl_wr & pwdata[CTRL_RX_FLUSH];
  assign ovr_set  = rx_valid & rx_full & ~rx_pop;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (pclk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (pwdata[DATA_W-1:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (pclk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // A new overrun in the same cycle as its clear wins, so no drop goes unreported.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      ctrl       <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl.rx_ie  <= pwdata[CTRL_RX_IE];
        ctrl.tx_ie  <= pwdata[CTRL_TX_IE];
        ctrl.ovr_ie <= pwdata[CTRL_OVR_IE];
      end
      rx_overrun <= ovr_set | (rx_overrun & ~(isr_wr & pwdata[ISR_OVERRUN]));
    end
  end

  always_comb begin
    status = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_OVERRUN]  = rx_overrun;
    status[ST_TX_LVL_LSB +: LVL_FIELD_W] = LVL_FIELD_W'(tx_level);
    status[ST_RX_LVL_LSB +: LVL_FIELD_W] = LVL_FIELD_W'(rx_level);
  end

  always_comb begin
    prdata = '0;
    if (rd_ok) begin
      case (sel)
        SEL_DATA:   prdata = 32'(rx_head);
        SEL_STATUS: prdata = status;
        SEL_CTRL:   prdata = {29'd0, ctrl.ovr_ie, ctrl.tx_ie, ctrl.rx_ie};
        SEL_ISR:    prdata = {27'd0, rx_overrun, 4'd0};
        default:    prdata = '0;
      endcase
    end
  end

  assign pready   = access;
  assign pslverr  = err;
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_head;
  assign irq      = (ctrl.rx_ie & ~rx_empty) | (ctrl.tx_ie & tx_empty) | (ctrl.ovr_ie & rx_overrun);

  assign unused_bits = ^{padd[31:4], pwdata, pstrb[3:1]};

endmodule

// File: tb/tb_uart_apb_fifo.sv
// tb/tb_uart_apb_fifo.sv - randomized and directed checks of uart_apb_fifo against a queue-based model
module tb_uart_apb_fifo;

  localparam int D = 16;

  logic        pclk;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] padd, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, irq;

  uart_apb_fifo #(.DATA_W(8), .FIFO_DEPTH(D)) dut (
    .pclk(pclk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .padd(padd), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;

  bit [7:0] txq[$];
  bit [7:0] rxq[$];
  bit       ovr;
  bit [2:0] ie;

  logic [31:0] last_prdata;
  logic        last_pslverr, last_tx_valid, last_irq;
  logic [7:0]  last_tx_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] model_status();
    bit [31:0] s;
    s = 0;
    s[0] = txq.size() == 0;
    s[1] = txq.size() == D;
    s[2] = rxq.size() == 0;
    s[3] = rxq.size() == D;
    s[4] = ovr;
    s[15:8]  = 8'(txq.size());
    s[23:16] = 8'(rxq.size());
    return s;
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    ovr = 0;
    ie  = 0;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model.
  task automatic step();
    bit acc, err, wr, rd, tx_pop, rx_pop, rx_was_full, ovr_new;
    bit [1:0]  sel;
    bit [31:0] ep;
    @(negedge pclk);
    acc = psel & penable;
    sel = padd[3:2];
    err = 0;
    if (acc) begin
      if (padd[1:0] != 0) err = 1;
      else if (pwrite && sel == 1) err = 1;
      else if (pwrite && sel == 0 && (txq.size() == D || !pstrb[0])) err = 1;
      else if (!pwrite && sel == 0 && rxq.size() == 0) err = 1;
    end
    wr = acc & pwrite & !err;
    rd = acc & !pwrite & !err;
    ep = 0;
    if (rd) begin
      case (sel)
        2'd0: ep = 32'(rxq[0]);
        2'd1: ep = model_status();
        2'd2: ep = 32'(ie);
        2'd3: ep = 32'(ovr) << 4;
      endcase
    end
    last_prdata = prdata; last_pslverr = pslverr; last_tx_valid = tx_valid;
    last_tx_data = tx_data; last_irq = irq;
    check_eq("pready", pready, 32'(acc));
    check_eq("pslverr", pslverr, 32'(err));
    check_eq("prdata", prdata, ep);
    check_eq("tx_valid", tx_valid, 32'(txq.size() != 0));
    check_eq("tx_data", tx_data, txq.size() != 0 ? 32'(txq[0]) : 32'd0);
    check_eq("irq", irq, 32'((ie[0] && rxq.size() != 0) || (ie[1] && txq.size() == 0) || (ie[2] && ovr)));

    tx_pop = txq.size() != 0 && tx_ready;
    rx_pop = rd && sel == 0;
    rx_was_full = rxq.size() == D;
    if (tx_pop) void'(txq.pop_front());
    if (wr && sel == 0) txq.push_back(pwdata[7:0]);
    if (rx_pop) void'(rxq.pop_front());
    ovr_new = rx_valid && rx_was_full && !rx_pop;
    if (rx_valid && !ovr_new) rxq.push_back(rx_data);
    if (wr && sel == 3 && pwdata[4]) ovr = 0;
    if (ovr_new) ovr = 1;
    if (wr && sel == 2) begin
      ie = pwdata[2:0];
      if (pwdata[3]) txq.delete();
      if (pwdata[4]) rxq.delete();
    end
    @(posedge pclk);
    #1;
    rx_valid = 0;
  endtask

  task automatic apb(input bit w, input bit [31:0] a, input bit [31:0] d, input bit [3:0] s,
                     input bit rv, input bit [7:0] rdat);
    psel = 1; penable = 0; pwrite = w; padd = a; pwdata = d; pstrb = s;
    step();
    penable = 1; rx_valid = rv; rx_data = rdat;
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic wr_reg(input bit [31:0] a, input bit [31:0] d);
    apb(1, a, d, 4'hF, 0, 8'h00);
  endtask

  task automatic rd_reg(input bit [31:0] a);
    apb(0, a, 32'h0, 4'h0, 0, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0]  rx_first;
    bit [31:0] a, d;
    bit [3:0]  s;
    bit        rv;
    int        r;

    rst = 1; psel = 0; penable = 0; pwrite = 0; padd = 0; pwdata = 0; pstrb = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0;
    model_reset();
    #2;
    check_eq("rst_pready", pready, 0);
    check_eq("rst_irq", irq, 0);
    repeat (2) @(posedge pclk);
    #1 rst = 0;
    step();
    rd_reg(32'h4);
    check_eq("rst_status", last_prdata, 32'h0000_0005);

    // TX ordering with the core stalled, then draining
    wr_reg(32'h0, 32'h41);
    wr_reg(32'h0, 32'h42);
    rd_reg(32'h4);
    check_eq("tx_lvl2", last_prdata[15:8], 2);
    tx_ready = 1;
    step(); check_eq("tx_head0", last_tx_data, 8'h41);
    step(); check_eq("tx_head1", last_tx_data, 8'h42);
    step(); check_eq("tx_drained", last_tx_valid, 0);
    tx_ready = 0;
    rd_reg(32'h4);
    check_eq("tx_empty_bit", last_prdata[0], 1);

    // TX full rejects a 17th write without disturbing the head
    for (int i = 0; i < D; i++) wr_reg(32'h0, 32'(8'h10 + i));
    wr_reg(32'h0, 32'hEE);
    check_eq("tx_full_err", last_pslverr, 1);
    rd_reg(32'h4);
    check_eq("tx_lvl16", last_prdata[15:8], 16);
    check_eq("tx_full_head", last_tx_data, 8'h10);
    wr_reg(32'h8, 32'h08);
    rd_reg(32'h4);
    check_eq("tx_flushed", last_prdata[15:8], 0);

    // RX overrun, interrupt and clear
    for (int i = 0; i < D + 1; i++) begin
      rx_valid = 1; rx_data = 8'($urandom);
      if (i == 0) rx_first = rx_data;
      step();
    end
    wr_reg(32'h8, 32'h04);
    step();
    check_eq("ovr_irq", last_irq, 1);
    rd_reg(32'h4);
    check_eq("rx_full_bit", last_prdata[3], 1);
    check_eq("ovr_bit", last_prdata[4], 1);
    wr_reg(32'hC, 32'h10);
    rd_reg(32'hC);
    check_eq("ovr_cleared", last_prdata, 0);

    // RX full: simultaneous receive and read keeps level, no overrun
    apb(0, 32'h0, 32'h0, 4'h0, 1, 8'hC3);
    check_eq("rx_oldest", last_prdata, 32'(rx_first));
    rd_reg(32'h4);
    check_eq("rx_lvl16", last_prdata[23:16], 16);
    check_eq("no_ovr", last_prdata[4], 0);

    // Error paths change nothing
    wr_reg(32'h8, 32'h10);
    rd_reg(32'h0);
    check_eq("rx_empty_err", last_pslverr, 1);
    check_eq("rx_empty_prdata", last_prdata, 0);
    apb(1, 32'h0, 32'h77, 4'hE, 0, 8'h00);
    check_eq("strb_err", last_pslverr, 1);
    wr_reg(32'h4, 32'h0);
    check_eq("status_wr_err", last_pslverr, 1);
    rd_reg(32'h4);
    check_eq("no_push", last_prdata[15:8], 0);
    wr_reg(32'h8, 32'h1F);
    rd_reg(32'h8);
    check_eq("ctrl_rb", last_prdata, 32'h7);

    // Reset in the middle of an access
    wr_reg(32'h8, 32'h0);
    for (int i = 0; i < 3; i++) wr_reg(32'h0, 32'(8'hA0 + i));
    psel = 1; penable = 0; pwrite = 1; padd = 0; pwdata = 32'h99; pstrb = 4'h1;
    step();
    penable = 1;
    #2 rst = 1;
    #1;
    check_eq("mid_rst_pready", pready, 0);
    check_eq("mid_rst_pslverr", pslverr, 0);
    check_eq("mid_rst_prdata", prdata, 0);
    check_eq("mid_rst_tx_valid", tx_valid, 0);
    check_eq("mid_rst_tx_data", tx_data, 0);
    check_eq("mid_rst_irq", irq, 0);
    psel = 0; penable = 0; pwrite = 0;
    @(posedge pclk);
    #1 rst = 0;
    model_reset();
    step();
    wr_reg(32'h0, 32'h5A);
    rd_reg(32'h4);
    check_eq("post_rst_lvl1", last_prdata[15:8], 1);
    check_eq("post_rst_rx_empty", last_prdata[2], 1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      tx_ready = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 2) == 0);
      a = $urandom();
      d = $urandom();
      s = 4'($urandom);
      case (r)
        0, 1, 2: begin
          a[3:0] = 4'h0;
          if ($urandom_range(0, 7) != 0) s[0] = 1'b1;
          apb(1, a, d, s, rv, 8'($urandom));
        end
        3, 4: begin a[3:0] = 4'h0; apb(0, a, d, s, rv, 8'($urandom)); end
        5: begin a[3:0] = 4'h4; apb($urandom_range(0, 7) == 0, a, d, s, rv, 8'($urandom)); end
        6: begin
          a[3:0] = 4'h8;
          d[4:3] = ($urandom_range(0, 7) == 0) ? d[4:3] : 2'b00;
          apb($urandom_range(0, 1), a, d, s, rv, 8'($urandom));
        end
        7: begin a[3:0] = 4'hC; apb($urandom_range(0, 1), a, d, s, rv, 8'($urandom)); end
        8: begin
          a[1:0] = 2'($urandom_range(1, 3));
          apb($urandom_range(0, 1), a, d, s, rv, 8'($urandom));
        end
        default: begin rx_valid = rv; rx_data = 8'($urandom); step(); end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
